// File: rtl/subvec_collector.sv
// subvec_collector
// Reassembles SUB_VECTOR_NO bus-wide beats into one VECTOR_WIDTH-bit
// fingerprint vector. It captures the vector ID on beat 0 and the popcount
// on the final beat. Finished vectors are queued in a 2-entry output buffer.
// up_Ready doubles as the stall enable of the upstream counter pipeline, so
// it is derived only from registered state. err_Frame is a sticky flag for
// framing violations and is cleared only by rst.
module subvec_collector #(
  parameter int VECTOR_WIDTH  = 920,
  parameter int BUS_WIDTH     = 128,
  parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int VEC_ID_WIDTH  = 16,
  parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    up_SubVector,
  input  logic [VEC_ID_WIDTH-1:0] up_ID,
  input  logic                    up_Valid,
  input  logic [CNT_WIDTH-1:0]    up_Cnt,
  input  logic                    up_CntNew,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [VECTOR_WIDTH-1:0] dn_Vector,
  output logic [VEC_ID_WIDTH-1:0] dn_ID,
  output logic [CNT_WIDTH-1:0]    dn_Cnt,
  output logic                    dn_Last,
  output logic                    dn_Valid,
  input  logic                    dn_Ready,
  output logic                    err_Frame
);

  // The assembly buffer spans every beat in full. The padding above
  // VECTOR_WIDTH in the final beat is stored but never leaves the block.
  localparam int ASM_WIDTH = SUB_VECTOR_NO * BUS_WIDTH;
  localparam int WC_WIDTH  = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam logic [WC_WIDTH-1:0] WC_ZERO = {WC_WIDTH{1'b0}};
  localparam logic [WC_WIDTH-1:0] WC_ONE  = WC_WIDTH'(1);
  localparam logic [WC_WIDTH-1:0] WC_LAST = WC_WIDTH'(SUB_VECTOR_NO - 1);

  // One output-buffer entry.
  typedef struct packed {
    logic [VECTOR_WIDTH-1:0] vec;
    logic [VEC_ID_WIDTH-1:0] id;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    last;
  } entry_t;

  localparam entry_t ENTRY_ZERO = {$bits(entry_t){1'b0}};

  // Assembly state
  logic [WC_WIDTH-1:0]     wc_q, wc_d;
  logic [ASM_WIDTH-1:0]    asm_q, asm_d;
  logic [VEC_ID_WIDTH-1:0] id_q, id_d;

  // Output buffer state: head_q drives the dn_* outputs, tail_q is the second slot
  logic [1:0]              occ_q, occ_d;
  entry_t                  head_q, head_d;
  entry_t                  tail_q, tail_d;

  // Registered status outputs
  logic                    up_ready_q;
  logic                    dn_valid_q;
  logic                    err_q;

  // Beat classification
  logic                    accept_s;
  logic                    final_beat_s;
  logic                    complete_s;
  logic                    pop_s;
  logic                    id_bad_s;
  logic                    early_s;
  logic                    missing_s;
  logic                    last_bad_s;
  logic                    err_set_s;
  entry_t                  push_entry_s;

  assign accept_s     = up_Valid && up_ready_q;
  assign final_beat_s = (wc_q == WC_LAST);
  assign complete_s   = accept_s && final_beat_s && up_CntNew;
  assign pop_s        = dn_valid_q && dn_Ready;

  // Framing violations. Each one is judged only on an accepted beat.
  assign id_bad_s   = accept_s && (wc_q != WC_ZERO) && (up_ID != id_q);
  assign early_s    = accept_s && up_CntNew && !final_beat_s;
  assign missing_s  = accept_s && !up_CntNew && final_beat_s;
  assign last_bad_s = accept_s && up_Last && !complete_s;
  assign err_set_s  = id_bad_s || early_s || missing_s || last_bad_s;

  // Merge the accepted beat into its slot of the assembly buffer (beat 0 at the LSBs).
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < SUB_VECTOR_NO; k++) begin
      if (accept_s && (wc_q == WC_WIDTH'(k))) begin
        asm_d[k*BUS_WIDTH +: BUS_WIDTH] = up_SubVector;
      end else begin
        asm_d[k*BUS_WIDTH +: BUS_WIDTH] = asm_q[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Word counter and ID capture. Any end-of-vector event restarts framing at beat 0.
  always_comb begin
    wc_d = wc_q;
    id_d = id_q;
    if (accept_s) begin
      if (up_CntNew || final_beat_s) begin
        wc_d = WC_ZERO;
      end else begin
        wc_d = wc_q + WC_ONE;
      end
      if (wc_q == WC_ZERO) begin
        id_d = up_ID;
      end else begin
        id_d = id_q;
      end
    end else begin
      wc_d = wc_q;
      id_d = id_q;
    end
  end

  // Build the entry pushed on normal completion. A one-beat vector takes its ID from the live beat.
  always_comb begin
    push_entry_s      = ENTRY_ZERO;
    push_entry_s.vec  = asm_d[VECTOR_WIDTH-1:0];
    push_entry_s.id   = (wc_q == WC_ZERO) ? up_ID : id_q;
    push_entry_s.cnt  = up_Cnt;
    push_entry_s.last = up_Last;
  end

  // Two-slot output buffer: a push into an empty buffer (or a push with a pop at occ=1) lands in the head.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({complete_s, pop_s})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          head_d = push_entry_s;
        end else begin
          tail_d = push_entry_s;
        end
      end
      2'b01: begin
        occ_d = occ_q - 2'd1;
        if (occ_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
      end
      2'b11: begin
        occ_d = occ_q;
        if (occ_q == 2'd1) begin
          head_d = push_entry_s;
        end else begin
          // A full buffer cannot accept a beat. This branch keeps ordering intact if it ever could.
          head_d = tail_q;
          tail_d = push_entry_s;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Assembly registers. The upstream freeze holds them because accept_s is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc_q  <= WC_ZERO;
      asm_q <= {ASM_WIDTH{1'b0}};
      id_q  <= {VEC_ID_WIDTH{1'b0}};
    end else begin
      wc_q  <= wc_d;
      asm_q <= asm_d;
      id_q  <= id_d;
    end
  end

  // Output buffer and registered handshake/status outputs, all derived from next-state occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      head_q     <= ENTRY_ZERO;
      tail_q     <= ENTRY_ZERO;
      dn_valid_q <= 1'b0;
      up_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      dn_valid_q <= (occ_d != 2'd0);
      up_ready_q <= (occ_d != 2'd2);
      err_q      <= err_q || err_set_s;
    end
  end

  assign up_Ready  = up_ready_q;
  assign dn_Valid  = dn_valid_q;
  assign dn_Vector = head_q.vec;
  assign dn_ID     = head_q.id;
  assign dn_Cnt    = head_q.cnt;
  assign dn_Last   = head_q.last;
  assign err_Frame = err_q;

endmodule

// File: tb/tb_subvec_collector.sv
// Scoreboard bench for subvec_collector. Stimulus tasks push the expected
// entries into a queue. An independent monitor pops and compares each entry
// whenever the DUT completes an output handshake.
module tb_subvec_collector;

  localparam int VW  = 920;
  localparam int BW  = 128;
  localparam int SVN = 8;
  localparam int IW  = 16;
  localparam int CW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] up_SubVector = '0;
  logic [IW-1:0] up_ID = '0;
  logic          up_Valid = 1'b0;
  logic [CW-1:0] up_Cnt = '0;
  logic          up_CntNew = 1'b0;
  logic          up_Last = 1'b0;
  logic          up_Ready;
  logic [VW-1:0] dn_Vector;
  logic [IW-1:0] dn_ID;
  logic [CW-1:0] dn_Cnt;
  logic          dn_Last;
  logic          dn_Valid;
  logic          dn_Ready = 1'b1;
  logic          err_Frame;

  typedef struct packed {
    logic [VW-1:0] vec;
    logic [IW-1:0] id;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  subvec_collector #(
    .VECTOR_WIDTH (VW),
    .BUS_WIDTH    (BW),
    .SUB_VECTOR_NO(SVN),
    .VEC_ID_WIDTH (IW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_SubVector(up_SubVector),
    .up_ID       (up_ID),
    .up_Valid    (up_Valid),
    .up_Cnt      (up_Cnt),
    .up_CntNew   (up_CntNew),
    .up_Last     (up_Last),
    .up_Ready    (up_Ready),
    .dn_Vector   (dn_Vector),
    .dn_ID       (dn_ID),
    .dn_Cnt      (dn_Cnt),
    .dn_Last     (dn_Last),
    .dn_Valid    (dn_Valid),
    .dn_Ready    (dn_Ready),
    .err_Frame   (err_Frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    logic [SVN*BW-1:0] a;
    logic [SVN*BW-1:0] r;
    n_checks++;
    if (act === req) n_pass++;
    else begin
      a = '0; r = '0;
      a[VW-1:0] = act;
      r[VW-1:0] = req;
      for (int k = 0; k < SVN; k++)
        if (a[k*BW +: BW] !== r[k*BW +: BW])
          $display("FAIL %s beat %0d: got 0x%032h, required 0x%032h", nm, k, a[k*BW +: BW], r[k*BW +: BW]);
    end
  endtask

  // Beat k of a vector with the given seed: every byte equals seed+k.
  function automatic logic [BW-1:0] beat(input logic [7:0] seed, input int k);
    logic [7:0] b;
    b = seed + 8'(k);
    return {16{b}};
  endfunction

  function automatic logic [VW-1:0] mk_vec(input logic [7:0] seed);
    logic [SVN*BW-1:0] full;
    for (int k = 0; k < SVN; k++) full[k*BW +: BW] = beat(seed, k);
    return full[VW-1:0];
  endfunction

  // Offer one beat and hold it until accepted. Called and returns at posedge+1.
  task automatic send_beat(input logic [BW-1:0] d, input logic [IW-1:0] id, input logic cn,
                           input logic [CW-1:0] cnt, input logic last);
    int n;
    n = 0;
    up_SubVector = d; up_ID = id; up_CntNew = cn; up_Cnt = cnt; up_Last = last;
    up_Valid = 1'b1;
    @(negedge clk);
    while (!up_Ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      $display("FAIL beat_accept_timeout: got no accept in %0d cycles, required accept", n);
    end
    @(posedge clk);
    #1;
    up_Valid = 1'b0; up_CntNew = 1'b0; up_Last = 1'b0;
  endtask

  // Send nbeats beats. CntNew goes on beat cntnew_at, and beat badid_at carries a wrong ID.
  task automatic send_vec(input logic [IW-1:0] id, input logic [7:0] seed, input logic [CW-1:0] cnt,
                          input logic last, input int nbeats, input int cntnew_at,
                          input int badid_at, input logic expect_out);
    exp_t e;
    if (expect_out) begin
      e.vec = mk_vec(seed); e.id = id; e.cnt = cnt; e.last = last;
      exp_q.push_back(e);
    end
    for (int k = 0; k < nbeats; k++)
      send_beat(beat(seed, k), (k == badid_at) ? (id ^ 16'h0001) : id,
                k == cntnew_at, cnt, last && (k == nbeats - 1));
  endtask

  // Pulse rst for one edge, then check that every output shows its reset value.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    up_Valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk({nm, "_dn_valid"}, 64'(dn_Valid), 64'h0);
    chk({nm, "_up_ready"}, 64'(up_Ready), 64'h1);
    chk({nm, "_err"}, 64'(err_Frame), 64'h0);
    chk({nm, "_dn_id"}, 64'(dn_ID), 64'h0);
    chk({nm, "_dn_cnt"}, 64'(dn_Cnt), 64'h0);
    chk({nm, "_dn_last"}, 64'(dn_Last), 64'h0);
    chk({nm, "_dn_vec_zero"}, 64'(dn_Vector == '0), 64'h1);
  endtask

  // Monitor: compare each output entry against the scoreboard when the handshake completes.
  always @(negedge clk) begin
    if (!rst && dn_Valid && dn_Ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got ID 0x%0h, required no output", dn_ID);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_id", 64'(dn_ID), 64'(mon_e.id));
        chk("out_cnt", 64'(dn_Cnt), 64'(mon_e.cnt));
        chk("out_last", 64'(dn_Last), 64'(mon_e.last));
        chk_vec("out_vec", dn_Vector, mon_e.vec);
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    do_reset("init");

    // Single vector, one-cycle latency with an empty buffer
    dn_Ready = 1'b1;
    send_vec(16'h0005, 8'h01, 10'h0A3, 1'b0, 8, 7, -1, 1'b1);
    chk("t1_valid", 64'(dn_Valid), 64'h1);
    chk("t1_lo_hi", dn_Vector[127:64], 64'h0101010101010101);
    chk("t1_lo_lo", dn_Vector[63:0], 64'h0101010101010101);
    chk("t1_top", 64'(dn_Vector[919:896]), 64'h080808);
    chk("t1_id", 64'(dn_ID), 64'h0005);
    chk("t1_cnt", 64'(dn_Cnt), 64'h0A3);
    chk("t1_err", 64'(err_Frame), 64'h0);
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: three vectors while the output is stalled
    dn_Ready = 1'b0;
    fork
      begin
        send_vec(16'h0001, 8'h11, 10'h011, 1'b0, 8, 7, -1, 1'b1);
        send_vec(16'h0002, 8'h21, 10'h022, 1'b0, 8, 7, -1, 1'b1);
        send_vec(16'h0003, 8'h31, 10'h033, 1'b0, 8, 7, -1, 1'b1);
      end
      begin
        repeat (12) @(negedge clk);
        chk("bp_ready_occ1", 64'(up_Ready), 64'h1);
        repeat (8) @(negedge clk);
        chk("bp_ready_full", 64'(up_Ready), 64'h0);
        chk("bp_held_valid", 64'(up_Valid), 64'h1);
        chk("bp_held_id", 64'(up_ID), 64'h0003);
        chk("bp_held_beat0", up_SubVector[63:0], 64'h3131313131313131);
        chk("bp_head_id", 64'(dn_ID), 64'h0001);
        chk("bp_head_valid", 64'(dn_Valid), 64'h1);
        @(posedge clk);
        #1;
        dn_Ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_err", 64'(err_Frame), 64'h0);

    // Stream end
    send_vec(16'h00FF, 8'hF0, 10'h3FF, 1'b1, 8, 7, -1, 1'b1);
    chk("end_last", 64'(dn_Last), 64'h1);
    chk("end_id", 64'(dn_ID), 64'h00FF);
    chk("end_err", 64'(err_Frame), 64'h0);

    // Early CntNew on beat 4: drop the vector, flag the error, then recover
    send_vec(16'h0008, 8'h80, 10'h010, 1'b0, 5, 4, -1, 1'b0);
    chk("early_err", 64'(err_Frame), 64'h1);
    chk("early_no_out", 64'(dn_Valid), 64'h0);
    send_vec(16'h0009, 8'h90, 10'h155, 1'b0, 8, 7, -1, 1'b1);
    chk("early_next_id", 64'(dn_ID), 64'h0009);
    repeat (2) @(posedge clk);
    #1;

    // Reset with a full buffer
    dn_Ready = 1'b0;
    send_vec(16'h0021, 8'h21, 10'h021, 1'b0, 8, 7, -1, 1'b1);
    send_vec(16'h0022, 8'h22, 10'h022, 1'b0, 8, 7, -1, 1'b1);
    chk("full_ready", 64'(up_Ready), 64'h0);
    do_reset("rst_full");

    // Reset with one entry buffered, wc=5 and the error flag set
    send_vec(16'h0031, 8'h31, 10'h031, 1'b0, 8, 7, -1, 1'b1);
    send_vec(16'h0032, 8'h32, 10'h032, 1'b0, 5, -1, 2, 1'b0);
    chk("mid_err", 64'(err_Frame), 64'h1);
    do_reset("rst_mid");
    dn_Ready = 1'b1;
    send_vec(16'h0042, 8'h42, 10'h042, 1'b0, 8, 7, -1, 1'b1);
    chk("post_rst_id", 64'(dn_ID), 64'h0042);
    chk("post_rst_err", 64'(err_Frame), 64'h0);

    // ID mismatch on beat 3: emitted with the beat-0 ID and the error flag set
    send_vec(16'h0006, 8'h60, 10'h066, 1'b0, 8, 7, 3, 1'b1);
    chk("idmm_id", 64'(dn_ID), 64'h0006);
    chk("idmm_err", 64'(err_Frame), 64'h1);

    // Drain the scoreboard
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/subvec_collector.md
# subvec_collector

Downstream receiver for the sub-vector stream produced by the bit-count stage. It reassembles `SUB_VECTOR_NO` bus-wide beats into one `VECTOR_WIDTH`-bit fingerprint vector and captures the vector's ID and the total popcount delivered with the last beat. Completed vectors go into a 2-entry output buffer for the comparison stage. The block drives the upstream ready, which the counter pipeline uses as its global stall enable, and it flags framing violations.

## Interface
- `VECTOR_WIDTH`, 920, full vector width in bits.
- `BUS_WIDTH`, 128, beat width in bits.
- `SUB_VECTOR_NO`, ceil(`VECTOR_WIDTH`/`BUS_WIDTH`), beats per vector.
- `VEC_ID_WIDTH`, 16, vector ID width.
- `CNT_WIDTH`, clog2(`VECTOR_WIDTH`), popcount width.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `up_SubVector`  in  `BUS_WIDTH`  beat data.
- `up_ID`  in  `VEC_ID_WIDTH`  vector ID, repeated on every beat.
- `up_Valid`  in  1  beat valid.
- `up_Cnt`  in  `CNT_WIDTH`  total popcount; meaningful only when `up_CntNew`=1.
- `up_CntNew`  in  1  marks the final beat of a vector.
- `up_Last`  in  1  marks the final beat of the stream.
- `up_Ready`  out  1  beat accept / upstream pipeline enable.
- `dn_Vector`  out  `VECTOR_WIDTH`  assembled vector.
- `dn_ID`  out  `VEC_ID_WIDTH`  ID of the vector.
- `dn_Cnt`  out  `CNT_WIDTH`  popcount of the vector.
- `dn_Last`  out  1  the vector ends the stream.
- `dn_Valid`  out  1  output vector valid.
- `dn_Ready`  in  1  downstream accept.
- `err_Frame`  out  1  sticky framing error; cleared only by `rst`.

## Operation
- A beat is accepted when `up_Valid && up_Ready`. Nothing else changes state on the input side.
- Word counter `wc` runs 0..`SUB_VECTOR_NO`-1.
- Packing: beat `wc` is written to `asm[wc*BUS_WIDTH +: BUS_WIDTH]`, with beat 0 at the LSBs.
- On the final beat, only the low `VECTOR_WIDTH-(SUB_VECTOR_NO-1)*BUS_WIDTH` bits are kept. The padding bits are discarded.
- The ID is captured on beat 0.
- On any later beat, an `up_ID` that differs from the captured ID sets `err_Frame`. Assembly continues with the beat-0 ID.
- Normal completion: an accepted beat with `wc`=`SUB_VECTOR_NO`-1 and `up_CntNew`=1.
  - Pushes {asm including this beat, ID, `up_Cnt`, `up_Last`} into the output buffer.
  - Sets `wc` to 0.
- Early `up_CntNew` (`wc`<`SUB_VECTOR_NO`-1):
  - Sets `err_Frame`.
  - Drops the partial vector with no push.
  - Sets `wc` to 0.
- Missing `up_CntNew` at `wc`=`SUB_VECTOR_NO`-1:
  - Sets `err_Frame`.
  - Drops the vector.
  - Sets `wc` to 0.
- `up_Last` on a beat that is not a normal completion:
  - Sets `err_Frame`.
  - No push occurs, so no `dn_Last` vector is emitted.
- Output buffer: 2-entry FIFO with occupancy `occ` in 0..2. The head entry drives the `dn_*` outputs.
  - `dn_Valid` = (`occ` != 0).
  - A pop occurs when `dn_Valid && dn_Ready`.
- `up_Ready` = (`occ` != 2). It is a function of registered state only, with no combinational path from `dn_Ready` or `up_Valid`.
- Simultaneous push and pop:
  - `occ` is unchanged.
  - With `occ`=1, the new entry becomes head on the next cycle.
  - With `occ`=2, no push is possible because `up_Ready`=0.
- While `up_Ready`=0 the upstream pipeline is frozen. `wc` and `asm` hold their values.

## Timing
- Reset values:
  - `up_Ready`=1.
  - `dn_Valid`=0, `dn_Vector`=0, `dn_ID`=0, `dn_Cnt`=0, `dn_Last`=0.
  - `err_Frame`=0, `wc`=0, `occ`=0.
- Latency: the final beat is accepted in cycle t. With an empty FIFO, `dn_*` are valid in cycle t+1.
- Throughput: one vector per `SUB_VECTOR_NO` cycles sustained with `dn_Ready`=1. The FIFO never fills in that case.
- `up_Ready` falls in the cycle after the push that makes `occ`=2. It rises in the cycle after the first pop from full.
- Output entries are stable while `dn_Valid`=1 and `dn_Ready`=0.
- `err_Frame` asserts in the cycle after the offending beat is accepted.
- `rst` asserted mid-vector or with the FIFO non-empty:
  - The partial vector and all buffered entries are discarded.
  - All outputs take their reset values in the following cycle.

## Test plan
Parameters for all scenarios: `VECTOR_WIDTH`=920, `BUS_WIDTH`=128, `SUB_VECTOR_NO`=8.
- Single vector: 8 beats, beat k = {16{8'(k+1)}}, ID=0x0005, CntNew with Cnt=0x0A3 on beat 7, `dn_Ready`=1. Required response: one output the cycle after beat 7; bits[127:0]=0x01.., bits[919:896]=0x080808; ID=0x0005; Cnt=0x0A3; Last=0; `err_Frame`=0.
- Back-pressure: three vectors back-to-back (IDs 1,2,3), `dn_Ready`=0 until all beats are offered. Required response: `up_Ready` goes to 0 after vector 2 is pushed; vector 3 beat 0 is held. After `dn_Ready`=1, outputs appear in order 1,2,3 with no loss or duplication.
- Stream end: `up_Last`=1 with `up_CntNew` on beat 7 of ID 0x00FF. Required response: the output has `dn_Last`=1 and ID=0x00FF.
- Early CntNew: asserted on beat 4. Required response: no output, `err_Frame`=1, and the next 8 beats (ID 9) produce a correct vector ID 9.
- ID mismatch: beat 3 carries ID 0x0007 within ID 0x0006. Required response: the vector is emitted with ID 0x0006 and `err_Frame`=1.
- Reset with `occ`=2 and `wc`=5. Required response: the next cycle has `dn_Valid`=0, `up_Ready`=1, `err_Frame`=0; a following full vector is emitted correctly.
